instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
- Instruction-fetch (IF) stage of the pipeline. Acts as the requesting side of the instruction-memory interface.
- Owns the program counter and drives a word address to the instruction memory. The memory returns the 32-bit word combinationally in the same cycle.
- Registers the word with its next-PC into the IF/ID pipeline latch.
- Handles stall, branch redirect (with bubble insertion), wrap-around, and halt on a sentinel instruction.

Parameters:
- MEM_DEPTH, 128, number of 32-bit words in instruction memory; PC wraps modulo this value (power of two).
- RESET_PC, 0, word address loaded into PC on reset.
- NOP_INSTR, 32'h00000000, instruction word placed in IF/ID on bubble/reset.
- HALT_INSTR, 32'hFFFFFFFF, fetched word that stops fetching.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- mem_addr  output  32  word address to instruction memory (= PC, zero-extended)
- mem_data  input  32  instruction word returned combinationally for mem_addr
- stall  input  1  hazard unit: hold PC and IF/ID
- branch_taken  input  1  redirect request from a later stage
- branch_target  input  32  word address for redirect
- if_id_instr  output  32  latched instruction
- if_id_npc  output  32  latched PC+1 of that instruction (wrapped)
- if_id_valid  output  1  IF/ID holds a real instruction
- halted  output  1  fetch stopped on HALT_INSTR
- fetch_count  output  16  number of instructions latched valid since reset

Behaviour:
- Reset (rst=1 at edge), which overrides everything:
  - PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_npc=0, if_id_valid=0, halted=0, fetch_count=0.
  - Reset mid-stall or mid-halt recovers fully.
- mem_addr = PC at all times; it is combinational from the PC register. Memory latency is zero; IF/ID latency is 1 cycle.
- State machine, 2 states:
  - RUN: normal fetch.
  - HALT: entered at the edge where a word equal to HALT_INSTR is latched into IF/ID.
  - HALT exits only by reset or branch_taken.
- Priority per edge in RUN: branch_taken > stall > normal.
- Normal:
  - PC <= (PC+1) mod MEM_DEPTH.
  - IF/ID <= {mem_data, (PC+1) mod MEM_DEPTH, valid=1}.
  - fetch_count increments; it saturates at 16'hFFFF.
  - If mem_data==HALT_INSTR: latch it valid, count it, then go to HALT. PC is not incremented.
- stall=1 (no branch): PC, IF/ID and fetch_count hold.
- branch_taken=1:
  - PC <= branch_target mod MEM_DEPTH (low bits only).
  - IF/ID <= {NOP_INSTR, 0, valid=0}. This flushes the wrong-path fetch and applies even if stall=1 in the same cycle.
  - Count unchanged.
- HALT:
  - PC holds.
  - IF/ID <= bubble {NOP_INSTR, 0, valid=0} on the first HALT cycle, then holds.
  - halted=1.
  - branch_taken in HALT: PC <= target, halted=0, return to RUN, IF/ID bubble.
- Wrap-around: PC = MEM_DEPTH-1 increments to 0; npc latched as 0.
- The upper mem_addr bits above log2(MEM_DEPTH) are always 0.

Test Plan:
- Reset then sequential fetch:
  - Stimulus: rst for 2 cycles, then release; memory holds words 0x11,0x22,0x33 at addresses 0..2.
  - Required: mem_addr = 0,1,2,3 on successive cycles. if_id_instr = 0x11,0x22,0x33 with npc = 1,2,3 and valid=1 one cycle later. fetch_count = 3.
- Stall:
  - Stimulus: stall=1 for 2 cycles while PC=5.
  - Required: mem_addr stays 5, IF/ID unchanged, count unchanged. After release, word[5] latches with npc=6.
- Branch redirect, plus simultaneous stall:
  - Stimulus: branch_taken=1, target=40, stall=1 at PC=7.
  - Required: next PC=40, if_id_valid=0, if_id_instr=0. The following edge latches word[40] with npc=41.
- Wrap and target truncation:
  - Stimulus: target=127, then free-run; separately target=130.
  - Required: addresses 127,0 with npc 0 for word[127]. Target 130 yields PC=2.
- Halt and restart:
  - Stimulus: word[9]=0xFFFFFFFF.
  - Required: FFFFFFFF latched valid, halted=1, PC stays 9, next IF/ID is a bubble, count frozen.
  - Then: branch_taken target=0 gives halted=0 and fetch resumes at 0.
- Reset mid-halt:
  - Stimulus: rst=1 while halted.
  - Required: all outputs return to reset values on that edge; fetch resumes from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory word
// address, and registers the returned word with its next-PC into IF/ID.
// Handles stall, branch redirect with bubble, PC wrap and halt-on-sentinel.
module instr_fetch_stage #(
  parameter int unsigned MEM_DEPTH  = 128,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_npc,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n, pc_inc;
  logic [31:0]   instr_n, npc_n;
  logic          valid_n;
  logic [15:0]   count_n;

  // PC is kept at the memory's index width, so the +1 wraps modulo MEM_DEPTH
  // for free and the upper address bits are constant zero.
  assign pc_inc   = pc + AW'(1);
  assign mem_addr = {{(32-AW){1'b0}}, pc};
  assign halted   = (state == HALT);

  // Next-state and datapath selection: branch beats stall beats normal fetch.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = if_id_instr;
    npc_n   = if_id_npc;
    valid_n = if_id_valid;
    count_n = fetch_count;
    case (state)
      RUN: begin
        if (branch_taken) begin
          pc_n    = branch_target[AW-1:0];
          instr_n = NOP_INSTR;
          npc_n   = '0;
          valid_n = 1'b0;
        end else if (!stall) begin
          instr_n = mem_data;
          npc_n   = {{(32-AW){1'b0}}, pc_inc};
          valid_n = 1'b1;
          if (fetch_count != '1) begin
            count_n = fetch_count + 16'd1;
          end
          // The sentinel is latched and counted, but the PC stays on it.
          if (mem_data == HALT_INSTR) begin
            state_n = HALT;
          end else begin
            pc_n = pc_inc;
          end
        end
      end
      HALT: begin
        // Writing the bubble every halted cycle equals "bubble once, then hold".
        instr_n = NOP_INSTR;
        npc_n   = '0;
        valid_n = 1'b0;
        if (branch_taken) begin
          pc_n    = branch_target[AW-1:0];
          state_n = RUN;
        end
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  // State register with synchronous reset overriding every other request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC[AW-1:0];
      if_id_instr <= NOP_INSTR;
      if_id_npc   <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_id_instr <= instr_n;
      if_id_npc   <= npc_n;
      if_id_valid <= valid_n;
      fetch_count <= count_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a combinational instruction memory.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [128];
  int checks = 0;
  int errors = 0;

  instr_fetch_stage #(
    .MEM_DEPTH (128),
    .RESET_PC  (32'h0),
    .NOP_INSTR (32'h0),
    .HALT_INSTR(32'hFFFF_FFFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_id_instr  (if_id_instr),
    .if_id_npc    (if_id_npc),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr[6:0]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                        input logic [31:0] npc, input logic valid, input logic hlt,
                        input logic [15:0] cnt);
    chk({tag, ".addr"},   mem_addr, addr);
    chk({tag, ".instr"},  if_id_instr, instr);
    chk({tag, ".npc"},    if_id_npc, npc);
    chk({tag, ".valid"},  {31'b0, if_id_valid}, {31'b0, valid});
    chk({tag, ".halted"}, {31'b0, halted}, {31'b0, hlt});
    chk({tag, ".count"},  {16'b0, fetch_count}, {16'b0, cnt});
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[9] = 32'hFFFF_FFFF;

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    step(); step();
    chk_if("reset", 32'd0, 32'h0, 32'd0, 1'b0, 1'b0, 16'd0);

    // sequential fetch
    rst = 1'b0;
    step(); chk_if("seq0", 32'd1, 32'h11, 32'd1, 1'b1, 1'b0, 16'd1);
    step(); chk_if("seq1", 32'd2, 32'h22, 32'd2, 1'b1, 1'b0, 16'd2);
    step(); chk_if("seq2", 32'd3, 32'h33, 32'd3, 1'b1, 1'b0, 16'd3);
    step(); step();
    chk_if("to5", 32'd5, 32'hA000_0004, 32'd5, 1'b1, 1'b0, 16'd5);

    // stall holds everything
    stall = 1'b1;
    step(); chk_if("stall0", 32'd5, 32'hA000_0004, 32'd5, 1'b1, 1'b0, 16'd5);
    step(); chk_if("stall1", 32'd5, 32'hA000_0004, 32'd5, 1'b1, 1'b0, 16'd5);
    stall = 1'b0;
    step(); chk_if("unstall", 32'd6, 32'hA000_0005, 32'd6, 1'b1, 1'b0, 16'd6);
    step(); chk_if("to7", 32'd7, 32'hA000_0006, 32'd7, 1'b1, 1'b0, 16'd7);

    // branch with simultaneous stall flushes
    branch_taken = 1'b1; branch_target = 32'd40; stall = 1'b1;
    step(); chk_if("br40", 32'd40, 32'h0, 32'd0, 1'b0, 1'b0, 16'd7);
    branch_taken = 1'b0; stall = 1'b0;
    step(); chk_if("w40", 32'd41, 32'hA000_0028, 32'd41, 1'b1, 1'b0, 16'd8);

    // wrap at the top of memory
    branch_taken = 1'b1; branch_target = 32'd127;
    step(); chk_if("br127", 32'd127, 32'h0, 32'd0, 1'b0, 1'b0, 16'd8);
    branch_taken = 1'b0;
    step(); chk_if("wrap", 32'd0, 32'hA000_007F, 32'd0, 1'b1, 1'b0, 16'd9);
    step(); chk_if("after_wrap", 32'd1, 32'h11, 32'd1, 1'b1, 1'b0, 16'd10);

    // target truncation
    branch_taken = 1'b1; branch_target = 32'd130;
    step(); chk_if("br130", 32'd2, 32'h0, 32'd0, 1'b0, 1'b0, 16'd10);

    // halt on sentinel at word 9
    branch_target = 32'd8;
    step(); chk_if("br8", 32'd8, 32'h0, 32'd0, 1'b0, 1'b0, 16'd10);
    branch_taken = 1'b0;
    step(); chk_if("w8", 32'd9, 32'hA000_0008, 32'd9, 1'b1, 1'b0, 16'd11);
    step(); chk_if("halt_latch", 32'd9, 32'hFFFF_FFFF, 32'd10, 1'b1, 1'b1, 16'd12);
    step(); chk_if("halt_bubble", 32'd9, 32'h0, 32'd0, 1'b0, 1'b1, 16'd12);
    step(); chk_if("halt_hold", 32'd9, 32'h0, 32'd0, 1'b0, 1'b1, 16'd12);

    // branch restarts from halt
    branch_taken = 1'b1; branch_target = 32'd0;
    step(); chk_if("restart", 32'd0, 32'h0, 32'd0, 1'b0, 1'b0, 16'd12);
    branch_taken = 1'b0;
    step(); chk_if("resume", 32'd1, 32'h11, 32'd1, 1'b1, 1'b0, 16'd13);

    // halt again, then reset out of it
    branch_taken = 1'b1; branch_target = 32'd9;
    step(); chk_if("br9", 32'd9, 32'h0, 32'd0, 1'b0, 1'b0, 16'd13);
    branch_taken = 1'b0;
    step(); chk_if("halt2", 32'd9, 32'hFFFF_FFFF, 32'd10, 1'b1, 1'b1, 16'd14);
    step(); chk_if("halt2_bubble", 32'd9, 32'h0, 32'd0, 1'b0, 1'b1, 16'd14);
    rst = 1'b1;
    step(); chk_if("rst_halt", 32'd0, 32'h0, 32'd0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    step(); chk_if("post_rst", 32'd1, 32'h11, 32'd1, 1'b1, 1'b0, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
